cnu_serial: RTL and testbench

Serial offset-min-sum Check Node Unit for the LDPC decoder. It consumes the 6-bit variable-to-check messages produced by the VNU, one edge per cycle, and tracks min1, min2, the min1 index, the sign product and the hard-decision parity. It then streams DEG 5-bit sign-magnitude check-to-variable messages back in the VNU X input format. The block is double-banked, so frame k+1 accumulates while frame k is emitted.

---
 rtl/ldpc_pkg.sv | 28 ++
 rtl/cnu_serial_if.sv | 25 ++
 rtl/cnu_min_tracker.sv | 31 +++
 rtl/cnu_serial.sv | 201 ++++++++++++++++++++
 tb/tb_cnu_serial.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC message widths and typedefs used by the check-node unit.
package ldpc_pkg;

  localparam int unsigned MAG_W  = 4;
  localparam int unsigned CMSG_W = 5;
  localparam int unsigned VMSG_W = 6;

  typedef logic [MAG_W-1:0] mag_t;

  localparam mag_t MAG_MAX = 4'd15;

  // Variable-to-check message from the VNU.
  typedef struct packed {
    logic hd;
    logic sign;
    mag_t mag;
  } vmsg_t;

  // Check-to-variable message in the VNU X input format.
  typedef struct packed {
    logic sign;
    mag_t mag;
  } cmsg_t;

  typedef enum logic {StAcc, StWait} in_st_e;
  typedef enum logic {StIdle, StEmit} out_st_e;

endpackage

// File: rtl/cnu_serial_if.sv
// Handshake bundle between the VNU side and the serial CNU.
interface cnu_serial_if;
  import ldpc_pkg::*;

  logic  in_valid;
  vmsg_t in_data;
  logic  in_ready;
  logic  out_valid;
  cmsg_t out_data;
  logic  out_last;
  logic  out_ready;
  logic  parity_valid;
  logic  parity_ok;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, parity_valid, parity_ok
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, parity_valid, parity_ok
  );

endinterface

// File: rtl/cnu_min_tracker.sv
// Combinational min1/min2/index next-value logic; registers live in the parent.
module cnu_min_tracker
  import ldpc_pkg::*;
#(
  parameter int unsigned IdxW = 3
) (
  input  mag_t            mag_i,
  input  logic [IdxW-1:0] cnt_i,
  input  mag_t            min1_i,
  input  mag_t            min2_i,
  input  logic [IdxW-1:0] idx_i,
  output mag_t            min1_o,
  output mag_t            min2_o,
  output logic [IdxW-1:0] idx_o
);

  // Strict compares: an equal later value never displaces min1, it lands in min2.
  always_comb begin
    min1_o = min1_i;
    min2_o = min2_i;
    idx_o  = idx_i;
    if (mag_i < min1_i) begin
      min2_o = min1_i;
      min1_o = mag_i;
      idx_o  = cnt_i;
    end else if (mag_i < min2_i) begin
      min2_o = mag_i;
    end
  end

endmodule

// File: rtl/cnu_serial.sv
// Serial offset-min-sum check node unit, double-banked: one frame accumulates
// while the previous frame is emitted.
module cnu_serial
  import ldpc_pkg::*;
#(
  parameter int unsigned DEG    = 6,
  parameter int unsigned OFFSET = 0
) (
  input logic         clk,
  input logic         rst_n,
  cnu_serial_if.slave bus
);

  localparam int unsigned IdxW = (DEG > 1) ? $clog2(DEG) : 1;
  typedef logic [IdxW-1:0] idx_t;
  localparam idx_t LastIdx = idx_t'(DEG - 1);
  localparam mag_t OffMag  = mag_t'(OFFSET);

  // Accumulation bank
  in_st_e         in_st_q, in_st_d;
  idx_t           in_cnt_q, in_cnt_d;
  mag_t           min1_q, min1_d, min2_q, min2_d;
  idx_t           idx_q, idx_d;
  logic           sign_acc_q, sign_acc_d, par_acc_q, par_acc_d;
  logic [DEG-1:0] sign_mem_q, sign_mem_d;

  // Output bank
  out_st_e        out_st_q, out_st_d;
  idx_t           out_cnt_q, out_cnt_d;
  mag_t           b_min1_q, b_min1_d, b_min2_q, b_min2_d;
  idx_t           b_idx_q, b_idx_d;
  logic           b_sign_q, b_sign_d;
  logic [DEG-1:0] b_sign_mem_q, b_sign_mem_d;
  cmsg_t          out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic           par_valid_q, par_valid_d, par_ok_q, par_ok_d;

  // Frame values including the beat accepted this cycle
  mag_t           trk_min1, trk_min2, fr_min1, fr_min2;
  idx_t           trk_idx, fr_idx;
  logic           fr_sign, fr_par;
  logic [DEG-1:0] fr_sign_mem;
  logic           accept, out_hs, bank_free, last_acc, transfer;

  function automatic cmsg_t beat_msg(idx_t i, mag_t m1, mag_t m2, idx_t ix, logic s,
                                     logic [DEG-1:0] smem);
    mag_t  m;
    cmsg_t r;
    m      = (i == ix) ? m2 : m1;
    r.mag  = (m > OffMag) ? m - OffMag : '0;
    r.sign = (r.mag != '0) & (s ^ smem[i]);
    return r;
  endfunction

  cnu_min_tracker #(
    .IdxW (IdxW)
  ) u_min_tracker (
    .mag_i  (bus.in_data.mag),
    .cnt_i  (in_cnt_q),
    .min1_i (min1_q),
    .min2_i (min2_q),
    .idx_i  (idx_q),
    .min1_o (trk_min1),
    .min2_o (trk_min2),
    .idx_o  (trk_idx)
  );

  // Handshake decode and the transfer condition shared by both sides.
  always_comb begin
    accept    = bus.in_valid && (in_st_q == StAcc);
    out_hs    = (out_st_q == StEmit) && bus.out_ready;
    bank_free = (out_st_q == StIdle) || (out_hs && out_last_q);
    last_acc  = accept && (in_cnt_q == LastIdx);
    transfer  = bank_free && (last_acc || (in_st_q == StWait));

    fr_min1     = accept ? trk_min1 : min1_q;
    fr_min2     = accept ? trk_min2 : min2_q;
    fr_idx      = accept ? trk_idx : idx_q;
    fr_sign     = sign_acc_q ^ (accept & bus.in_data.sign);
    fr_par      = par_acc_q ^ (accept & bus.in_data.hd);
    fr_sign_mem = sign_mem_q;
    if (accept) fr_sign_mem[in_cnt_q] = bus.in_data.sign;
  end

  // Input FSM and accumulator next state.
  always_comb begin
    in_st_d    = in_st_q;
    in_cnt_d   = in_cnt_q;
    min1_d     = fr_min1;
    min2_d     = fr_min2;
    idx_d      = fr_idx;
    sign_acc_d = fr_sign;
    par_acc_d  = fr_par;
    sign_mem_d = fr_sign_mem;
    if (accept) in_cnt_d = last_acc ? '0 : in_cnt_q + idx_t'(1);
    if (transfer) begin
      min1_d     = MAG_MAX;
      min2_d     = MAG_MAX;
      idx_d      = '0;
      sign_acc_d = 1'b0;
      par_acc_d  = 1'b0;
      sign_mem_d = '0;
    end
    unique case (in_st_q)
      StAcc:   if (last_acc && !bank_free) in_st_d = StWait;
      StWait:  if (bank_free) in_st_d = StAcc;
      default: in_st_d = StAcc;
    endcase
  end

  // Output FSM, bank load and registered output beat.
  always_comb begin
    out_st_d     = out_st_q;
    out_cnt_d    = out_cnt_q;
    b_min1_d     = b_min1_q;
    b_min2_d     = b_min2_q;
    b_idx_d      = b_idx_q;
    b_sign_d     = b_sign_q;
    b_sign_mem_d = b_sign_mem_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    par_valid_d  = 1'b0;
    par_ok_d     = par_ok_q;
    if (transfer) begin
      b_min1_d     = fr_min1;
      b_min2_d     = fr_min2;
      b_idx_d      = fr_idx;
      b_sign_d     = fr_sign;
      b_sign_mem_d = fr_sign_mem;
      out_st_d     = StEmit;
      out_cnt_d    = '0;
      out_data_d   = beat_msg('0, fr_min1, fr_min2, fr_idx, fr_sign, fr_sign_mem);
      out_last_d   = 1'b0;
      par_valid_d  = 1'b1;
      par_ok_d     = ~fr_par;
    end else if (out_hs) begin
      if (out_last_q) begin
        out_st_d   = StIdle;
        out_last_d = 1'b0;
      end else begin
        out_cnt_d  = out_cnt_q + idx_t'(1);
        out_data_d = beat_msg(out_cnt_q + idx_t'(1), b_min1_q, b_min2_q, b_idx_q, b_sign_q,
                              b_sign_mem_q);
        out_last_d = (out_cnt_q + idx_t'(1)) == LastIdx;
      end
    end
  end

  // State registers; reset discards both banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_st_q      <= StAcc;
      in_cnt_q     <= '0;
      min1_q       <= MAG_MAX;
      min2_q       <= MAG_MAX;
      idx_q        <= '0;
      sign_acc_q   <= 1'b0;
      par_acc_q    <= 1'b0;
      sign_mem_q   <= '0;
      out_st_q     <= StIdle;
      out_cnt_q    <= '0;
      b_min1_q     <= MAG_MAX;
      b_min2_q     <= MAG_MAX;
      b_idx_q      <= '0;
      b_sign_q     <= 1'b0;
      b_sign_mem_q <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      par_valid_q  <= 1'b0;
      par_ok_q     <= 1'b0;
    end else begin
      in_st_q      <= in_st_d;
      in_cnt_q     <= in_cnt_d;
      min1_q       <= min1_d;
      min2_q       <= min2_d;
      idx_q        <= idx_d;
      sign_acc_q   <= sign_acc_d;
      par_acc_q    <= par_acc_d;
      sign_mem_q   <= sign_mem_d;
      out_st_q     <= out_st_d;
      out_cnt_q    <= out_cnt_d;
      b_min1_q     <= b_min1_d;
      b_min2_q     <= b_min2_d;
      b_idx_q      <= b_idx_d;
      b_sign_q     <= b_sign_d;
      b_sign_mem_q <= b_sign_mem_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      par_valid_q  <= par_valid_d;
      par_ok_q     <= par_ok_d;
    end
  end

  assign bus.in_ready     = (in_st_q == StAcc);
  assign bus.out_valid    = (out_st_q == StEmit);
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.parity_valid = par_valid_q;
  assign bus.parity_ok    = par_ok_q;

endmodule

// File: tb/tb_cnu_serial.sv
// Directed bench for cnu_serial: two instances (OFFSET 0 and 3) share stimulus.
module tb_cnu_serial;
  import ldpc_pkg::*;

  logic clk;
  logic rst_n;

  cnu_serial_if if0 ();
  cnu_serial_if if3 ();

  cnu_serial #(.DEG(6), .OFFSET(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  cnu_serial #(.DEG(6), .OFFSET(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-beat fields packed with beat 0 in the low bits.
  typedef struct packed {
    logic [23:0] mags;
    logic [5:0]  sgn;
    logic [5:0]  hd;
    logic [29:0] exp0;
    logic [29:0] exp3;
    logic        pok;
  } vec_t;

  vec_t vecs [6];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] d);
    if0.in_valid = v;
    if0.in_data  = d;
    if3.in_valid = v;
    if3.in_data  = d;
  endtask

  task automatic set_ready(input logic r);
    if0.out_ready = r;
    if3.out_ready = r;
  endtask

  task automatic drive_beat(input vec_t v, input int i);
    set_in(1'b1, {v.hd[i], v.sgn[i], v.mags[4*i +: 4]});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  {if3.in_ready, if0.in_ready}, 2'b11);
    chk({tag, "_out_valid"}, {if3.out_valid, if0.out_valid}, 2'b00);
    chk({tag, "_out_data"},  {if3.out_data, if0.out_data}, 10'd0);
    chk({tag, "_out_last"},  {if3.out_last, if0.out_last}, 2'b00);
    chk({tag, "_par_valid"}, {if3.parity_valid, if0.parity_valid}, 2'b00);
    chk({tag, "_par_ok"},    {if3.parity_ok, if0.parity_ok}, 2'b00);
  endtask

  task automatic send_frame(input vec_t v);
    for (int i = 0; i < 6; i++) begin
      drive_beat(v, i);
      chk("send_in_ready", {if3.in_ready, if0.in_ready}, 2'b11);
      tick();
    end
    set_in(1'b0, 6'd0);
  endtask

  // Expects beat 0 in the current cycle and out_ready held at 1.
  task automatic recv_frame(input vec_t v);
    chk("recv_par_valid", {if3.parity_valid, if0.parity_valid}, 2'b11);
    chk("recv_par_ok", {if3.parity_ok, if0.parity_ok}, {v.pok, v.pok});
    for (int j = 0; j < 6; j++) begin
      chk("recv_out_valid", {if3.out_valid, if0.out_valid}, 2'b11);
      chk("recv_data_off0", if0.out_data, v.exp0[5*j +: 5]);
      chk("recv_data_off3", if3.out_data, v.exp3[5*j +: 5]);
      chk("recv_out_last", {if3.out_last, if0.out_last}, (j == 5) ? 2'b11 : 2'b00);
      if (j > 0) chk("recv_par_pulse", {if3.parity_valid, if0.parity_valid}, 2'b00);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t a;
    vec_t b;
    // basic frame
    vecs[0] = '{mags: {4'd5, 4'd12, 4'd4, 4'd9, 4'd2, 4'd7}, sgn: 6'b001001, hd: 6'b001101,
                exp0: {5'b00010, 5'b00010, 5'b10010, 5'b00010, 5'b00100, 5'b10010},
                exp3: {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000}, pok: 1'b0};
    // all 15
    vecs[1] = '{mags: {6{4'd15}}, sgn: 6'd0, hd: 6'd0,
                exp0: {6{5'b01111}}, exp3: {6{5'b01100}}, pok: 1'b1};
    // tie in min1/min2
    vecs[2] = '{mags: {4'd8, 4'd8, 4'd8, 4'd8, 4'd3, 4'd3}, sgn: 6'd0, hd: 6'd0,
                exp0: {6{5'b00011}}, exp3: {6{5'b00000}}, pok: 1'b1};
    // mixed signs, even sign product
    vecs[3] = '{mags: {4'd8, 4'd3, 4'd14, 4'd6, 4'd1, 4'd9}, sgn: 6'b101011, hd: 6'b110110,
                exp0: {5'b10001, 5'b00001, 5'b10001, 5'b00001, 5'b10011, 5'b10001},
                exp3: {6{5'b00000}}, pok: 1'b1};
    // zero magnitude forces sign 0
    vecs[4] = '{mags: {4'd15, 4'd7, 4'd2, 4'd5, 4'd5, 4'd0}, sgn: 6'b000001, hd: 6'b000001,
                exp0: {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010},
                exp3: {6{5'b00000}}, pok: 1'b0};
    // odd sign product, large magnitudes
    vecs[5] = '{mags: {4'd14, 4'd15, 4'd12, 4'd11, 4'd13, 4'd10}, sgn: 6'b000010, hd: 6'b000011,
                exp0: {5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b01010, 5'b11011},
                exp3: {5'b10111, 5'b10111, 5'b10111, 5'b10111, 5'b00111, 5'b11000}, pok: 1'b1};

    rst_n = 1'b0;
    set_in(1'b0, 6'd0);
    set_ready(1'b0);
    repeat (3) tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();

    // Table: one frame at a time.
    set_ready(1'b1);
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v]);
      recv_frame(vecs[v]);
    end
    chk("par_hold_valid", {if3.parity_valid, if0.parity_valid}, 2'b00);
    chk("par_hold_ok", {if3.parity_ok, if0.parity_ok}, 2'b11);

    // Streaming: 12 beats back-to-back.
    a = vecs[0];
    b = vecs[5];
    for (int c = 0; c < 19; c++) begin
      if (c < 6) drive_beat(a, c);
      else if (c < 12) drive_beat(b, c - 6);
      else set_in(1'b0, 6'd0);
      if (c < 12) chk("stream_in_ready", {if3.in_ready, if0.in_ready}, 2'b11);
      chk("stream_out_valid", if0.out_valid, (c >= 6) && (c < 18));
      if (c >= 6 && c < 18) begin
        chk("stream_data", if0.out_data,
            (c < 12) ? a.exp0[5*(c-6) +: 5] : b.exp0[5*(c-12) +: 5]);
        chk("stream_last", if0.out_last, ((c - 6) % 6) == 5);
      end
      chk("stream_par_valid", if0.parity_valid, (c == 6) || (c == 12));
      tick();
    end

    // Backpressure: frame 2 waits for frame 1's last handshake.
    set_ready(1'b0);
    send_frame(a);
    send_frame(b);
    for (int k = 0; k < 3; k++) begin
      chk("bp_wait_in_ready", {if3.in_ready, if0.in_ready}, 2'b00);
      chk("bp_hold_data", if0.out_data, a.exp0[4:0]);
      chk("bp_hold_valid", if0.out_valid, 1'b1);
      set_in(1'b1, 6'b110000);
      tick();
    end
    set_in(1'b0, 6'd0);
    set_ready(1'b1);
    for (int j = 0; j < 6; j++) begin
      chk("bp_drain_data", if0.out_data, a.exp0[5*j +: 5]);
      chk("bp_drain_last", if0.out_last, j == 5);
      chk("bp_drain_in_ready", if0.in_ready, 1'b0);
      tick();
    end
    chk("bp_resume_in_ready", {if3.in_ready, if0.in_ready}, 2'b11);
    recv_frame(b);

    // Reset mid-frame: 3 junk beats accepted, output stalled on beat 2.
    send_frame(b);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 6'b110000);
      set_ready(k < 2);
      tick();
    end
    set_in(1'b0, 6'd0);
    chk("mid_beat2", if0.out_data, b.exp0[14:10]);
    chk("mid_par_ok", if0.parity_ok, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    set_ready(1'b1);
    tick();
    send_frame(vecs[3]);
    recv_frame(vecs[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
